// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: buffers one result per execution-unit port and retires at most
// one register write/unlock per cycle, selecting pending slots round-robin.

package maverickOne_pkg;
  parameter int NUM_REGS = 64;
  parameter int XLEN     = 64;
endpackage

module regfile_wb_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int NR        = maverickOne_pkg::NUM_REGS,
  parameter int DW        = maverickOne_pkg::XLEN,
  parameter int AW        = $clog2(NR)
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [NUM_PORTS-1:0][AW-1:0]  req_addr_i,
  input  logic [NUM_PORTS-1:0][DW-1:0]  req_data_i,
  input  logic [NUM_PORTS-1:0]          req_valid_i,
  output logic [NUM_PORTS-1:0]          req_ready_o,
  output logic [AW-1:0]                 wr_unlock_addr_o,
  output logic [DW-1:0]                 wr_unlock_data_o,
  output logic                          wr_unlock_en_o,
  output logic                          busy_o
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = PW + 1;

  logic [NUM_PORTS-1:0]         slot_valid_q;
  logic [NUM_PORTS-1:0]         slot_valid_d;
  logic [NUM_PORTS-1:0][AW-1:0] slot_addr_q;
  logic [NUM_PORTS-1:0][DW-1:0] slot_data_q;
  logic [PW-1:0]                ptr_q;
  logic [PW-1:0]                ptr_d;

  logic [NUM_PORTS-1:0]         grant;
  logic                         grant_valid;
  logic [PW-1:0]                grant_idx;
  logic [CW-1:0]                cand;
  logic [NUM_PORTS-1:0]         accept;
  logic [NUM_PORTS-1:0]         load;

  logic                         wr_en_q;
  logic [AW-1:0]                wr_addr_q;
  logic [DW-1:0]                wr_data_q;

  // Round-robin search from ptr_q; the candidate index wraps by subtraction so
  // non-power-of-2 port counts never select a slot that does not exist.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    cand        = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      cand = CW'(ptr_q) + CW'(off);
      if (cand >= CW'(NUM_PORTS)) begin
        cand = cand - CW'(NUM_PORTS);
      end
      if (!grant_valid && slot_valid_q[cand[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Handshake: a result moves on a rising edge when req_valid_i[p] & req_ready_o[p].
  // The producer holds valid and payload steady until then; ready is a function of
  // slot occupancy and the current grant only, never of req_valid_i.
  assign req_ready_o = {NUM_PORTS{~arst_i}} & (~slot_valid_q | grant);
  assign accept      = req_valid_i & req_ready_o;

  // Writes to register 0 complete the handshake but are dropped here.
  always_comb begin
    load = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      load[p] = accept[p] & (req_addr_i[p] != '0);
    end
  end

  assign slot_valid_d = load | (slot_valid_q & ~grant);

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      if (grant_idx == PW'(NUM_PORTS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      slot_valid_q <= '0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      ptr_q        <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      ptr_q        <= ptr_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (load[p]) begin
          slot_addr_q[p] <= req_addr_i[p];
          slot_data_q[p] <= req_data_i[p];
        end
      end
    end
  end

  // Address/data hold their last value when idle; only the enable pulses.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= grant_valid;
      if (grant_valid) begin
        wr_addr_q <= slot_addr_q[grant_idx];
        wr_data_q <= slot_data_q[grant_idx];
      end
    end
  end

  assign wr_unlock_en_o   = wr_en_q;
  assign wr_unlock_addr_o = wr_addr_q;
  assign wr_unlock_data_o = wr_data_q;
  assign busy_o           = (|slot_valid_q) | wr_en_q;

  a_grant_onehot : assert property (@(posedge clk_i) disable iff (arst_i) $onehot0(grant));
  a_ptr_in_range : assert property (@(posedge clk_i) disable iff (arst_i) ptr_q < PW'(NUM_PORTS) || NUM_PORTS == (1 << PW));

endmodule
